pulse_stretcher: RTL and testbench
==================================

# pulse_stretcher

Converts single-cycle event pulses (as produced by the debounced one-shot path) back into clean, fixed-width level pulses that slow consumers can see: LEDs, external probes, display refresh strobes. Each accepted input pulse yields exactly one output pulse of HIGH_CYCLES clocks followed by a guard gap of GAP_CYCLES clocks. Pulses arriving while an output pulse or gap is in progress are counted and replayed in order, so no event is lost up to PENDING_MAX. It sits at the output side of the frequency-meter datapath, opposite the button-input conditioning.

## Interface
- INVERT_LOGIC, 0: 1 makes stretched_out active-low (idle high).
- HIGH_CYCLES, 5000: output active width in clk cycles; legal range ≥1.
- GAP_CYCLES, 5000: minimum inactive cycles between consecutive output pulses; legal range ≥1.
- PENDING_MAX, 15: saturation value of the pending-event counter; legal range ≥1.

- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- pulse_in  input  1  event strobe; every cycle sampled high counts as one event.
- stretched_out  output  1  stretched pulse, registered; polarity per INVERT_LOGIC.
- busy  output  1  high while in HIGH or GAP state, or while pending ≠ 0.
- pending  output  $clog2(PENDING_MAX+1)  queued events not yet started.
- overflow  output  1  sticky, present only with PULSE_STRETCHER_OVERFLOW_EN.

## Operation
- FSM states: IDLE, HIGH, GAP. Down-counter timer sized $clog2(max(HIGH_CYCLES,GAP_CYCLES)+1) bits.
- IDLE: pulse_in=1 → HIGH, timer loaded with HIGH_CYCLES-1; pending unchanged.
- HIGH: timer decrements; at timer=0 → GAP, timer loaded with GAP_CYCLES-1.
- GAP: timer decrements; at timer=0: if pending>0 or pulse_in=1 → HIGH (reload); else → IDLE.
- pending update in HIGH/GAP: +1 on pulse_in, −1 when GAP exits to HIGH with pending>0; both in the same cycle → unchanged. GAP exit with pending=0 and pulse_in=1 consumes pulse_in directly (pending stays 0).
- pending saturates at PENDING_MAX; further events dropped.
- stretched_out = INVERT_LOGIC ^ (state==HIGH), taken from a register, no combinational path from pulse_in.
- Reset (any time, including mid-pulse): state=IDLE, timer=0, pending=0, stretched_out=INVERT_LOGIC, busy=0, overflow=0.

## Timing
- Latency: pulse_in high at edge N (IDLE) → stretched_out active from edge N+1 for exactly HIGH_CYCLES cycles.
- Back-to-back replay period: HIGH_CYCLES+GAP_CYCLES cycles, no extra idle cycle between GAP end and next HIGH.
- pending and busy reflect the register state after each edge; an event at edge N is visible in pending at N+1.
- pulse_in held high for k cycles counts as k events.

## Configuration
- PULSE_STRETCHER_OVERFLOW_EN defined: overflow port exists; set on the first cycle an event arrives while pending=PENDING_MAX and not simultaneously decrementing; cleared only by rst.
- Undefined: no overflow port, no flag register; drops at saturation are silent.

## Structure
- pulse_stretcher_pkg: state enum (IDLE, HIGH, GAP), width helper function for timer and pending widths.
- One sub-module: cycle_timer (loadable down-counter with zero flag), parameterized by width.

## Test plan
(HIGH_CYCLES=4, GAP_CYCLES=2, PENDING_MAX=3, INVERT_LOGIC=0 unless stated)
- Reset then single pulse_in at cycle 10 → stretched_out high cycles 11–14, low from 15, busy low from 17, pending=0 throughout.
- Pulses at cycles 10, 12, 13 → output high 11–14, 17–20, 23–26; pending reads 1, 2, then 1, 0 at starts of second/third pulses.
- Five pulses at cycles 10–14 → pending saturates at 3, exactly 4 output pulses; with PULSE_STRETCHER_OVERFLOW_EN overflow=1 from cycle 15 onward.
- Pulse_in exactly on final GAP cycle with pending=0 → next HIGH starts next edge, pending stays 0.
- rst asserted mid-HIGH with pending=2 → outputs return immediately to stretched_out=0, pending=0, busy=0; no pulses replayed after release.
- INVERT_LOGIC=1 single pulse → stretched_out idles 1, low for 4 cycles, reset value 1.

Source files
------------

// File: rtl/pulse_stretcher_pkg.sv
// ---------------------------------------------------------------------------
// | Module   : pulse_stretcher_pkg                                          |
// | Purpose  : Shared state encoding and width helpers for pulse_stretcher. |
// | Revision : 1.0 - initial release                                        |
// ---------------------------------------------------------------------------
`default_nettype none

package pulse_stretcher_pkg;

  // Output pulse sequencing: idle, active pulse, guard gap.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    GAP  = 2'd2
  } state_t;

  // Bits needed to hold any value 0..max_value (at least one bit).
  function automatic int count_width(input int max_value);
    return (max_value < 1) ? 1 : $clog2(max_value + 1);
  endfunction

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pulse_stretcher_cycle_timer.sv
// ---------------------------------------------------------------------------
// | Module   : cycle_timer                                                  |
// | Purpose  : Loadable down-counter with a zero flag; load wins over       |
// |            decrement and the count holds at zero.                       |
// | Revision : 1.0 - initial release                                        |
// ---------------------------------------------------------------------------
`default_nettype none

module cycle_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             dec,
  output logic             zero
);

  logic [WIDTH-1:0] r_count;

  // Count register: reload on request, otherwise step down toward zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_value;
    end else if (dec && (r_count != '0)) begin
      r_count <= r_count - WIDTH'(1);
    end
  end

  assign zero = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/pulse_stretcher.sv
// ---------------------------------------------------------------------------
// | Module   : pulse_stretcher                                              |
// | Purpose  : Turns single-cycle event strobes into fixed-width level      |
// |            pulses separated by a guard gap, queueing events that arrive |
// |            while a pulse or gap is in progress.                         |
// | Options  : PULSE_STRETCHER_OVERFLOW_EN adds a sticky overflow port.     |
// | Revision : 1.0 - initial release                                        |
// ---------------------------------------------------------------------------
`default_nettype none

module pulse_stretcher
  import pulse_stretcher_pkg::*;
#(
  parameter int INVERT_LOGIC = 0,
  parameter int HIGH_CYCLES  = 5000,
  parameter int GAP_CYCLES   = 5000,
  parameter int PENDING_MAX  = 15
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                pulse_in,
  output logic                                stretched_out,
  output logic                                busy,
`ifdef PULSE_STRETCHER_OVERFLOW_EN
  output logic                                overflow,
`endif
  output logic [count_width(PENDING_MAX)-1:0] pending
);

  localparam int TW = count_width(max_of(HIGH_CYCLES, GAP_CYCLES));
  localparam int PW = count_width(PENDING_MAX);

  localparam logic [TW-1:0] HIGH_LOAD = TW'(HIGH_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LOAD  = TW'(GAP_CYCLES - 1);
  localparam logic [PW-1:0] PEND_MAX  = PW'(PENDING_MAX);
  localparam logic          INV_BIT   = (INVERT_LOGIC != 0);

  state_t          r_state;
  state_t          w_next_state;
  logic            w_timer_load;
  logic [TW-1:0]   w_timer_value;
  logic            w_timer_dec;
  logic            w_timer_zero;
  logic            w_pend_inc;
  logic            w_pend_dec;
  logic [PW-1:0]   r_pending;
  logic            r_out;

  cycle_timer #(
    .WIDTH (TW)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (w_timer_load),
    .load_value (w_timer_value),
    .dec        (w_timer_dec),
    .zero       (w_timer_zero)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state, timer control and pending-queue increment/decrement requests.
  always_comb begin
    w_next_state  = r_state;
    w_timer_load  = 1'b0;
    w_timer_value = HIGH_LOAD;
    w_timer_dec   = 1'b0;
    w_pend_inc    = 1'b0;
    w_pend_dec    = 1'b0;
    case (r_state)
      IDLE: begin
        // An event in IDLE starts a pulse directly and never touches the queue.
        if (pulse_in) begin
          w_next_state = HIGH;
          w_timer_load = 1'b1;
        end
      end
      HIGH: begin
        w_pend_inc = pulse_in;
        if (w_timer_zero) begin
          w_next_state  = GAP;
          w_timer_load  = 1'b1;
          w_timer_value = GAP_LOAD;
        end else begin
          w_timer_dec = 1'b1;
        end
      end
      GAP: begin
        w_pend_inc = pulse_in;
        if (w_timer_zero) begin
          if (r_pending != '0) begin
            // Replay the oldest queued event with no idle cycle in between.
            w_next_state = HIGH;
            w_timer_load = 1'b1;
            w_pend_dec   = 1'b1;
          end else if (pulse_in) begin
            // Empty queue: the arriving event is consumed by the new pulse.
            w_next_state = HIGH;
            w_timer_load = 1'b1;
            w_pend_inc   = 1'b0;
          end else begin
            w_next_state = IDLE;
          end
        end else begin
          w_timer_dec = 1'b1;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Pending counter: saturating increment, simultaneous inc/dec cancels.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pending <= '0;
    end else if (w_pend_inc && !w_pend_dec) begin
      if (r_pending != PEND_MAX) begin
        r_pending <= r_pending + PW'(1);
      end
    end else if (w_pend_dec && !w_pend_inc) begin
      r_pending <= r_pending - PW'(1);
    end
  end

  // Registered output, taken from the next state so it aligns with HIGH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out <= INV_BIT;
    end else begin
      r_out <= INV_BIT ^ (w_next_state == HIGH);
    end
  end

`ifdef PULSE_STRETCHER_OVERFLOW_EN
  logic r_overflow;

  // Sticky flag: an event was dropped because the queue was full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overflow <= 1'b0;
    end else if (w_pend_inc && !w_pend_dec && (r_pending == PEND_MAX)) begin
      r_overflow <= 1'b1;
    end
  end

  assign overflow = r_overflow;
`endif

  assign stretched_out = r_out;
  assign pending       = r_pending;
  assign busy          = (r_state != IDLE) || (r_pending != '0);

endmodule

`default_nettype wire

// File: tb/tb_pulse_stretcher.sv
// ---------------------------------------------------------------------------
// | Module   : tb_pulse_stretcher                                           |
// | Purpose  : Self-checking bench for pulse_stretcher (normal and inverted |
// |            polarity instances driven by the same stimulus).             |
// | Options  : PULSE_STRETCHER_OVERFLOW_EN also checks the overflow port.   |
// | Revision : 1.0 - initial release                                        |
// ---------------------------------------------------------------------------
`default_nettype none

module tb_pulse_stretcher;

  localparam int H = 4;
  localparam int G = 2;
  localparam int M = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       pulse_in = 1'b0;
  logic       out0, busy0, out1, busy1;
  logic [1:0] pend0, pend1;
`ifdef PULSE_STRETCHER_OVERFLOW_EN
  logic       ovf0, ovf1;
`endif

  pulse_stretcher #(
    .INVERT_LOGIC (0), .HIGH_CYCLES (H), .GAP_CYCLES (G), .PENDING_MAX (M)
  ) dut0 (
    .clk (clk), .rst (rst), .pulse_in (pulse_in),
    .stretched_out (out0), .busy (busy0),
`ifdef PULSE_STRETCHER_OVERFLOW_EN
    .overflow (ovf0),
`endif
    .pending (pend0)
  );

  pulse_stretcher #(
    .INVERT_LOGIC (1), .HIGH_CYCLES (H), .GAP_CYCLES (G), .PENDING_MAX (M)
  ) dut1 (
    .clk (clk), .rst (rst), .pulse_in (pulse_in),
    .stretched_out (out1), .busy (busy1),
`ifdef PULSE_STRETCHER_OVERFLOW_EN
    .overflow (ovf1),
`endif
    .pending (pend1)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Model: time of the latest pulse start, last cycle of its guard gap,
  // number of queued events and the sticky drop flag.
  int t;
  int m_start;
  int m_bend;
  int m_pend;
  bit m_ovf;

  logic [63:0] h_out;
  logic [63:0] h_busy;
  logic [63:0] h_ovf;
  int          h_pend [64];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s cycle=%0d actual=%0d required=%0d", name, t, got, exp);
    end
  endtask

  task automatic model_reset();
    t       = 0;
    m_start = -100;
    m_bend  = -100;
    m_pend  = 0;
    m_ovf   = 1'b0;
    h_out   = '0;
    h_busy  = '0;
    h_ovf   = '0;
    for (int i = 0; i < 64; i++) h_pend[i] = 0;
  endtask

  // Advance the model over the edge that ends cycle t with event p.
  task automatic model_step(input bit p);
    if (t > m_bend) begin
      if (p) begin
        m_start = t + 1;
        m_bend  = m_start + H + G - 1;
      end
    end else if (t == m_bend) begin
      if (m_pend > 0) begin
        m_pend  = m_pend - 1 + (p ? 1 : 0);
        m_start = t + 1;
        m_bend  = m_start + H + G - 1;
      end else if (p) begin
        m_start = t + 1;
        m_bend  = m_start + H + G - 1;
      end
    end else if (p) begin
      if (m_pend == M) m_ovf = 1'b1;
      else             m_pend = m_pend + 1;
    end
    t = t + 1;
  endtask

  task automatic compare_all();
    logic act;
    logic mbusy;
    act   = (t >= m_start) && (t <= m_start + H - 1);
    mbusy = (t <= m_bend) || (m_pend > 0);
    check("out_norm", 32'(out0), 32'(act));
    check("out_inv", 32'(out1), 32'(!act));
    check("busy_norm", 32'(busy0), 32'(mbusy));
    check("busy_inv", 32'(busy1), 32'(mbusy));
    check("pending_norm", 32'(pend0), 32'(m_pend));
    check("pending_inv", 32'(pend1), 32'(m_pend));
`ifdef PULSE_STRETCHER_OVERFLOW_EN
    check("overflow_norm", 32'(ovf0), 32'(m_ovf));
    check("overflow_inv", 32'(ovf1), 32'(m_ovf));
    if (t < 64) h_ovf[t] = ovf0;
`endif
    if (t < 64) begin
      h_out[t]  = out0;
      h_busy[t] = busy0;
      h_pend[t] = int'(pend0);
    end
  endtask

  task automatic step(input bit p);
    pulse_in = p;
    @(posedge clk);
    model_step(p);
    #1;
    compare_all();
  endtask

  // Asynchronous reset, checked while still asserted, released away from edges.
  task automatic apply_reset();
    pulse_in = 1'b0;
    rst      = 1'b1;
    #1;
    check("rst_out_norm", 32'(out0), 32'd0);
    check("rst_out_inv", 32'(out1), 32'd1);
    check("rst_busy", 32'(busy0), 32'd0);
    check("rst_pending", 32'(pend0), 32'd0);
`ifdef PULSE_STRETCHER_OVERFLOW_EN
    check("rst_overflow", 32'(ovf0), 32'd0);
`endif
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    compare_all();
  endtask

  task automatic run(input logic [63:0] mask, input int n);
    for (int i = 0; i < n; i++) step(mask[i]);
  endtask

  function automatic int rising_edges();
    int cnt;
    cnt = h_out[0] ? 1 : 0;
    for (int i = 1; i < 64; i++) if (h_out[i] && !h_out[i-1]) cnt++;
    return cnt;
  endfunction

  initial begin
    model_reset();

    // Single event at cycle 10.
    apply_reset();
    run(64'h0000_0000_0000_0400, 30);
    check("s1_out_c10", 32'(h_out[10]), 32'd0);
    check("s1_out_c11", 32'(h_out[11]), 32'd1);
    check("s1_out_c14", 32'(h_out[14]), 32'd1);
    check("s1_out_c15", 32'(h_out[15]), 32'd0);
    check("s1_busy_c16", 32'(h_busy[16]), 32'd1);
    check("s1_busy_c17", 32'(h_busy[17]), 32'd0);

    // Events at 10, 12, 13: replayed back to back.
    apply_reset();
    run(64'h0000_0000_0000_3400, 35);
    check("s2_out_c17", 32'(h_out[17]), 32'd1);
    check("s2_out_c21", 32'(h_out[21]), 32'd0);
    check("s2_out_c23", 32'(h_out[23]), 32'd1);
    check("s2_out_c27", 32'(h_out[27]), 32'd0);
    check("s2_pend_c13", 32'(h_pend[13]), 32'd1);
    check("s2_pend_c14", 32'(h_pend[14]), 32'd2);
    check("s2_pend_c17", 32'(h_pend[17]), 32'd1);
    check("s2_pend_c23", 32'(h_pend[23]), 32'd0);

    // Five consecutive events: queue saturates, one event dropped.
    apply_reset();
    run(64'h0000_0000_0000_7C00, 50);
    check("s3_pend_c14", 32'(h_pend[14]), 32'd3);
    check("s3_pulse_count", 32'(rising_edges()), 32'd4);
`ifdef PULSE_STRETCHER_OVERFLOW_EN
    check("s3_ovf_c14", 32'(h_ovf[14]), 32'd0);
    check("s3_ovf_c15", 32'(h_ovf[15]), 32'd1);
`endif

    // Event on the final gap cycle with an empty queue.
    apply_reset();
    run(64'h0000_0000_0000_0041, 20);
    check("s4_out_c6", 32'(h_out[6]), 32'd0);
    check("s4_out_c7", 32'(h_out[7]), 32'd1);
    check("s4_out_c10", 32'(h_out[10]), 32'd1);
    check("s4_out_c11", 32'(h_out[11]), 32'd0);
    check("s4_pend_c7", 32'(h_pend[7]), 32'd0);

    // Reset mid-pulse with two events queued: nothing replays afterwards.
    apply_reset();
    run(64'h0000_0000_0000_0007, 4);
    check("s5_pend_before", 32'(pend0), 32'd2);
    check("s5_out_before", 32'(out0), 32'd1);
    apply_reset();
    run(64'h0, 30);
    check("s5_pulse_count", 32'(rising_edges()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
